water_level_frame_gen: RTL and testbench

//  Builds the two 64-bit bicolour frames (red/green) consumed by the 8x8 LED matrix row scanner.

---
 rtl/water_level_frame_gen.sv | 170 +++++++++++++++++
 tb/tb_water_level_frame_gen.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/water_level_frame_gen.sv
// water_level_frame_gen
//   Builds the red and green 64-bit frames for an 8x8 bicolour LED matrix scanner.
//   A water column moves one row per animation step toward a target level. At or
//   above ALARM_LEVEL the column turns red and blinks until acknowledged.
//
// Ports
//   clk          system clock, all logic on posedge
//   rst          synchronous active-high reset
//   level_in     requested level 0..8 (9..15 clamp to 8)
//   level_valid  one-cycle strobe loading level_in as the new target
//   alarm_ack    clears the alarm once cur_level is below ALARM_LEVEL
//   picture_r    red frame, byte k = row k, row 0 = bottom
//   picture_g    green frame, same layout
//   cur_level    level currently displayed (0..8)
//   busy         1 while the column is moving (RISE or FALL)
//   alarm        latched alarm flag
//
// Build option
//   WAVE_ANIM_EN  when defined, the top filled row alternates 0xAA / 0x55 on
//                 successive animation steps.
//
// States
//   IDLE | cur_level equals target, column at rest
//   RISE | column climbing one row per step
//   FALL | column dropping one row per step
module water_level_frame_gen #(
  parameter int TICK_DIV    = 25000,
  parameter int ALARM_LEVEL = 6,
  parameter int BLINK_STEPS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  level_in,
  input  logic        level_valid,
  input  logic        alarm_ack,
  output logic [63:0] picture_r,
  output logic [63:0] picture_g,
  output logic [3:0]  cur_level,
  output logic        busy,
  output logic        alarm
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BW = (BLINK_STEPS > 1) ? $clog2(BLINK_STEPS) : 1;
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_STEPS - 1);
  localparam logic [3:0]    ALARM_LVL  = 4'(ALARM_LEVEL);

  typedef enum logic [1:0] {IDLE, RISE, FALL} state_t;

  state_t        state;
  logic [TW-1:0] tick_cnt;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;
  logic [3:0]    target;
  logic          step;
  logic [63:0]   fill;

  assign step = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk) begin
    if (rst)       tick_cnt <= '0;
    else if (step) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)              target <= 4'd0;
    else if (level_valid) target <= (level_in > 4'd8) ? 4'd8 : level_in;
  end

  // busy is assigned alongside every state change so it always equals (state != IDLE).
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cur_level <= 4'd0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cur_level < target) begin
            state <= RISE;
            busy  <= 1'b1;
          end else if (cur_level > target) begin
            state <= FALL;
            busy  <= 1'b1;
          end
        end
        RISE: begin
          if (cur_level == target) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (target < cur_level) begin
            state <= FALL;
          end else if (step && cur_level < 4'd8) begin
            cur_level <= cur_level + 4'd1;
          end
        end
        FALL: begin
          if (cur_level == target) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (target > cur_level) begin
            state <= RISE;
          end else if (step && cur_level > 4'd0) begin
            cur_level <= cur_level - 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Set has priority over acknowledge.
  always_ff @(posedge clk) begin
    if (rst)                            alarm <= 1'b0;
    else if (cur_level >= ALARM_LVL)    alarm <= 1'b1;
    else if (alarm_ack)                 alarm <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst || !alarm) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (step) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

`ifdef WAVE_ANIM_EN
  logic step_parity;

  always_ff @(posedge clk) begin
    if (rst)       step_parity <= 1'b0;
    else if (step) step_parity <= ~step_parity;
  end
`endif

  always_comb begin
    fill = '0;
    for (int k = 0; k < 8; k++) begin
      if (4'(k) < cur_level) fill[8*k +: 8] = 8'hFF;
`ifdef WAVE_ANIM_EN
      if (4'(k) + 4'd1 == cur_level) fill[8*k +: 8] = step_parity ? 8'h55 : 8'hAA;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      picture_r <= '0;
      picture_g <= '0;
    end else if (alarm) begin
      picture_r <= blink_phase ? 64'd0 : fill;
      picture_g <= '0;
    end else begin
      picture_r <= '0;
      picture_g <= fill;
    end
  end

endmodule

// File: tb/tb_water_level_frame_gen.sv
module tb_water_level_frame_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  level_in = 4'd0;
  logic        level_valid = 1'b0;
  logic        alarm_ack = 1'b0;
  logic [63:0] picture_r, picture_g;
  logic [3:0]  cur_level;
  logic        busy, alarm;

  int checks = 0;
  int failures = 0;

  localparam logic [63:0] ALLFF = 64'hFFFF_FFFF_FFFF_FFFF;

  water_level_frame_gen #(.TICK_DIV(4), .ALARM_LEVEL(6), .BLINK_STEPS(2)) dut (
    .clk(clk), .rst(rst), .level_in(level_in), .level_valid(level_valid),
    .alarm_ack(alarm_ack), .picture_r(picture_r), .picture_g(picture_g),
    .cur_level(cur_level), .busy(busy), .alarm(alarm)
  );

  always #5 clk = ~clk;

  // Reference step timing: the tick counter restarts at 0 after reset, so a step
  // happens on every edge where this counter reads 3. par_d is the step parity as it
  // stood before the latest edge, i.e. what the registered frame was built from.
  int   tb_tick = 0;
  logic par = 1'b0, par_d = 1'b0;
  always @(posedge clk) begin
    if (rst) begin
      tb_tick <= 0;
      par     <= 1'b0;
      par_d   <= 1'b0;
    end else begin
      tb_tick <= (tb_tick == 3) ? 0 : tb_tick + 1;
      if (tb_tick == 3) par <= ~par;
      par_d <= par;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] wave_fix(input logic [63:0] f, input int lvl);
    logic [63:0] r;
    r = f;
`ifdef WAVE_ANIM_EN
    if (lvl > 0) r[8*(lvl-1) +: 8] = par_d ? 8'h55 : 8'hAA;
`endif
    return r;
  endfunction

  task automatic load(input int v);
    level_in    = 4'(v);
    level_valid = 1'b1;
    @(negedge clk);
    level_valid = 1'b0;
  endtask

  task automatic pulse_ack();
    alarm_ack = 1'b1;
    @(negedge clk);
    alarm_ack = 1'b0;
  endtask

  task automatic settle(input string name);
    int n;
    n = 0;
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_settle"}, 64'(busy), 64'd0);
  endtask

  task automatic wait_level(input int v, input string name);
    int n;
    n = 0;
    while (cur_level != 4'(v) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(name, 64'(cur_level), 64'(v));
  endtask

  typedef struct {
    int          lvl;
    logic        ack;
    int          exp_lvl;
    logic [63:0] fill;
    logic        blink;
    logic        exp_alarm;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int t, last_t, nchg, saw6, nsamp, n;
    logic [3:0]  prev;
    logic [63:0] samp[8];

    tbl[0] = '{4, 1'b0, 4, 64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0};
    tbl[1] = '{1, 1'b0, 1, 64'h0000_0000_0000_00FF, 1'b0, 1'b0};
    tbl[2] = '{5, 1'b0, 5, 64'h0000_00FF_FFFF_FFFF, 1'b0, 1'b0};
    tbl[3] = '{0, 1'b0, 0, 64'h0000_0000_0000_0000, 1'b0, 1'b0};
    tbl[4] = '{7, 1'b0, 7, 64'h00FF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
    tbl[5] = '{3, 1'b1, 3, 64'h0000_0000_00FF_FFFF, 1'b0, 1'b0};
    tbl[6] = '{9, 1'b0, 8, ALLFF,                  1'b1, 1'b1};

    // Reset held for three cycles
    repeat (3) @(negedge clk);
    chk("rst_r", picture_r, 64'd0);
    chk("rst_g", picture_g, 64'd0);
    chk("rst_level", 64'(cur_level), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_alarm", 64'(alarm), 64'd0);
    rst = 1'b0;

    // Rise to 3: one row every 4 clocks, frame one cycle behind cur_level
    load(3);
    @(negedge clk);
    chk("rise_busy", 64'(busy), 64'd1);
    t = 0; last_t = -1; nchg = 0; prev = cur_level;
    while (busy && t < 100) begin
      @(negedge clk);
      t++;
      if (cur_level != prev) begin
        nchg++;
        chk("rise_val", 64'(cur_level), 64'(nchg));
        if (last_t >= 0) chk("rise_gap", 64'(t - last_t), 64'd4);
        if (cur_level == 4'd3) chk("rise_lag", picture_g, wave_fix(64'h0000_0000_0000_FFFF, 2));
        last_t = t;
        prev = cur_level;
      end
    end
    chk("rise_nchg", 64'(nchg), 64'd3);
    chk("rise_busy_end", 64'(busy), 64'd0);
    chk("rise_g", picture_g, wave_fix(64'h0000_0000_00FF_FFFF, 3));
    chk("rise_r", picture_r, 64'd0);

    // Reset mid-animation drops the pending target
    load(5);
    wait_level(4, "midrst_reach4");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_level", 64'(cur_level), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_g", picture_g, 64'd0);
    repeat (10) @(negedge clk);
    chk("midrst_hold_level", 64'(cur_level), 64'd0);
    chk("midrst_hold_busy", 64'(busy), 64'd0);

    // Reverse mid-rise at level 2 toward 0
    load(5);
    wait_level(2, "rev_reach2");
    load(0);
    t = 0; nchg = 0; prev = cur_level;
    @(negedge clk);
    while (busy && t < 100) begin
      if (cur_level != prev) begin
        nchg++;
        chk("rev_val", 64'(cur_level), 64'(2 - nchg));
        prev = cur_level;
      end
      @(negedge clk);
      t++;
    end
    chk("rev_nchg", 64'(nchg), 64'd2);
    chk("rev_level", 64'(cur_level), 64'd0);
    chk("rev_r", picture_r, 64'd0);
    chk("rev_g", picture_g, 64'd0);

    // Clamp 12 -> 8, alarm from level 6, blink, ack ignored at level 8
    load(12);
    @(negedge clk);
    t = 0; saw6 = -10; prev = cur_level;
    while (busy && t < 200) begin
      @(negedge clk);
      t++;
      if (t == saw6 + 1) chk("alarm_set", 64'(alarm), 64'd1);
      if (cur_level != prev) begin
        chk("clamp_noskip", 64'(cur_level), 64'(prev + 4'd1));
        if (cur_level == 4'd6) begin
          chk("alarm_pre", 64'(alarm), 64'd0);
          saw6 = t;
        end
        prev = cur_level;
      end
    end
    chk("clamp_level", 64'(cur_level), 64'd8);
    chk("clamp_g", picture_g, 64'd0);
    chk("clamp_alarm", 64'(alarm), 64'd1);
    nsamp = 0; n = 0;
    while (nsamp < 8 && n < 100) begin
      @(negedge clk);
      n++;
      if (tb_tick == 1) begin
        samp[nsamp] = picture_r;
        if (picture_r != 64'd0) chk("blink_fill", picture_r, wave_fix(ALLFF, 8));
        nsamp++;
      end
    end
    chk("blink_nsamp", 64'(nsamp), 64'd8);
    for (int j = 2; j < 8; j++)
      chk("blink_period", 64'((samp[j] == 64'd0) != (samp[j-2] == 64'd0)), 64'd1);
    pulse_ack();
    chk("ack_ignored", 64'(alarm), 64'd1);

    // Fall to 2, ack once below the alarm level
    load(2);
    wait_level(5, "ack_reach5");
    pulse_ack();
    chk("ack_clear", 64'(alarm), 64'd0);
    settle("ack");
    chk("ack_level", 64'(cur_level), 64'd2);
    chk("ack_g", picture_g, wave_fix(64'h0000_0000_0000_FFFF, 2));
    chk("ack_r", picture_r, 64'd0);

    // Table of settled levels
    for (int i = 0; i < 7; i++) begin
      load(tbl[i].lvl);
      @(negedge clk);
      settle("tbl");
      if (tbl[i].ack) begin
        pulse_ack();
        @(negedge clk);
      end
      chk("tbl_level", 64'(cur_level), 64'(tbl[i].exp_lvl));
      chk("tbl_alarm", 64'(alarm), 64'(tbl[i].exp_alarm));
      if (tbl[i].blink) begin
        chk("tbl_g", picture_g, 64'd0);
        chk("tbl_r_blink",
            64'(picture_r == 64'd0 || picture_r == wave_fix(tbl[i].fill, tbl[i].exp_lvl)), 64'd1);
      end else begin
        chk("tbl_g", picture_g, wave_fix(tbl[i].fill, tbl[i].exp_lvl));
        chk("tbl_r", picture_r, 64'd0);
      end
    end

`ifdef WAVE_ANIM_EN
    // Hold level 4: row 3 alternates AA/55 each step, rows 0..2 solid
    load(4);
    @(negedge clk);
    settle("wave");
    pulse_ack();
    @(negedge clk);
    nsamp = 0; n = 0;
    while (nsamp < 4 && n < 60) begin
      @(negedge clk);
      n++;
      if (tb_tick == 1) begin
        samp[nsamp] = picture_g;
        chk("wave_low", 64'(picture_g[23:0]), 64'h00FF_FFFF);
        chk("wave_top", 64'(picture_g[31:24] == 8'hAA || picture_g[31:24] == 8'h55), 64'd1);
        chk("wave_frame", picture_g, wave_fix(64'h0000_0000_FFFF_FFFF, 4));
        if (nsamp > 0) chk("wave_alt", 64'(samp[nsamp][31:24] != samp[nsamp-1][31:24]), 64'd1);
        nsamp++;
      end
    end
    chk("wave_nsamp", 64'(nsamp), 64'd4);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
